// File: rtl/memory_responder.sv
// Word-addressed memory responder with programmable access latency.
// Accepts one read or write at a time, waits LATENCY cycles, then pulses ack
// for one cycle. Malformed requests complete immediately with err and zero data.
module memory_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        Ren,
    input  logic        Wen,
    output logic [31:0] ramload,
    output logic        busy,
    output logic        ack,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [29:0] DepthW = 30'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   ramload_q, ramload_d;
    logic          access;
    logic          addr_ok;

    logic [31:0] mem_q [DEPTH];

    // Word-aligned and inside the array; upper address bits take part in the bound check.
    assign addr_ok = (ramaddr[1:0] == 2'b00) && (ramaddr[31:2] < DepthW);

    // Next-state logic; the access strobe uses the *_d captures so a zero-latency
    // request is serviced on the same edge it is accepted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        err_d     = err_q;
        ramload_d = ramload_q;
        access    = 1'b0;

        case (state_q)
            StIdle: begin
                if (Ren || Wen) begin
                    if ((Ren ^ Wen) && addr_ok) begin
                        addr_d = ramaddr[AW+1:2];
                        data_d = ramstore;
                        we_d   = Wen;
                        err_d  = 1'b0;
                        if (LATENCY > 0) begin
                            state_d = StWait;
                            cnt_d   = 4'(LATENCY);
                        end else begin
                            state_d = StResp;
                            access  = 1'b1;
                        end
                    end else begin
                        // Conflicting or out-of-range request: no wait, no memory effect.
                        state_d   = StResp;
                        err_d     = 1'b1;
                        ramload_d = 32'h0;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    access  = 1'b1;
                end
            end
            StResp: begin
                // Never samples a request here; a held request is taken next cycle.
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
        endcase

        if (access && !we_d) begin
            ramload_d = mem_q[addr_d];
        end
    end

    // Control and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= 32'h0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            ramload_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
            ramload_q <= ramload_d;
        end
    end

    // Storage array; every word clears on reset so an aborted write leaves nothing behind.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (access && we_d) begin
            mem_q[addr_d] <= data_d;
        end
    end

    assign ramload = ramload_q;
    assign busy    = (state_q != StIdle);
    assign ack     = (state_q == StResp);
    assign err     = err_q && (state_q == StResp);

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: one instance with LATENCY=2,
// one with LATENCY=0 and a small array.
module tb_memory_responder;

    logic clk = 1'b0;
    logic nRST = 1'b1;

    logic        ren2 = 1'b0, wen2 = 1'b0;
    logic [31:0] addr2 = 32'h0, store2 = 32'h0;
    logic [31:0] load2;
    logic        busy2, ack2, err2;

    logic        ren0 = 1'b0, wen0 = 1'b0;
    logic [31:0] addr0 = 32'h0, store0 = 32'h0;
    logic [31:0] load0;
    logic        busy0, ack0, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk(clk), .nRST(nRST), .ramaddr(addr2), .ramstore(store2),
        .Ren(ren2), .Wen(wen2), .ramload(load2), .busy(busy2), .ack(ack2), .err(err2)
    );

    memory_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk(clk), .nRST(nRST), .ramaddr(addr0), .ramstore(store0),
        .Ren(ren0), .Wen(wen0), .ramload(load0), .busy(busy0), .ack(ack0), .err(err0)
    );

    // Drive one request, hold it until ack, and report what was observed over 8 cycles.
    task automatic run_req(input bit use0, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int ack_at, output int ack_cnt, output int busy_cnt,
                           output int stray_err, output logic [31:0] load, output logic e);
        logic b, k, er;
        logic [31:0] ld;
        @(posedge clk); #1;
        if (use0) begin ren0 = r; wen0 = w; addr0 = a; store0 = d; end
        else begin ren2 = r; wen2 = w; addr2 = a; store2 = d; end
        ack_at = -1; ack_cnt = 0; busy_cnt = 0; stray_err = 0; load = 32'h0; e = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            b  = use0 ? busy0 : busy2;
            k  = use0 ? ack0 : ack2;
            er = use0 ? err0 : err2;
            ld = use0 ? load0 : load2;
            if (b) busy_cnt++;
            if (er && !k) stray_err++;
            if (k) begin
                ack_cnt++;
                if (ack_at < 0) begin
                    ack_at = i; load = ld; e = er;
                    if (use0) begin ren0 = 1'b0; wen0 = 1'b0; end
                    else begin ren2 = 1'b0; wen2 = 1'b0; end
                end
            end
        end
        if (use0) begin ren0 = 1'b0; wen0 = 1'b0; end
        else begin ren2 = 1'b0; wen2 = 1'b0; end
    endtask

    task automatic test_reset();
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({busy2, ack2, err2, load2} !== 35'h0) begin
            errors++;
            $display("FAIL reset_l2 got busy=%b ack=%b err=%b load=%h want all 0",
                     busy2, ack2, err2, load2);
        end
        checks++;
        if ({busy0, ack0, err0, load0} !== 35'h0) begin
            errors++;
            $display("FAIL reset_l0 got busy=%b ack=%b err=%b load=%h want all 0",
                     busy0, ack0, err0, load0);
        end
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;
    endtask

    task automatic test_write_read();
        int at, cnt, bc, se; logic [31:0] ld; logic e;
        run_req(1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 3 || cnt !== 1 || bc !== 3) begin
            errors++;
            $display("FAIL wr_timing got ack_at=%0d acks=%0d busy=%0d want 3 1 3", at, cnt, bc);
        end
        checks++;
        if (e !== 1'b0 || ld !== 32'h0 || se !== 0) begin
            errors++;
            $display("FAIL wr_resp got err=%b load=%h stray=%0d want 0 00000000 0", e, ld, se);
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 3 || bc !== 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_timing got ack_at=%0d busy=%0d err=%b want 3 3 0", at, bc, e);
        end
        checks++;
        if (ld !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rd_data got %h want cafef00d", ld);
        end
        // Held value persists after ack.
        repeat (2) @(posedge clk); #1;
        checks++;
        if (load2 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rd_hold got %h want cafef00d", load2);
        end
    endtask

    task automatic test_errors();
        int at, cnt, bc, se; logic [31:0] ld; logic e;
        logic [31:0] bad_addr [3];
        logic        both [3];
        bad_addr[0] = 32'h10; both[0] = 1'b1;
        bad_addr[1] = 32'h13; both[1] = 1'b0;
        bad_addr[2] = 32'h400; both[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, both[i], 1'b1, bad_addr[i], 32'hDEADBEEF, at, cnt, bc, se, ld, e);
            checks++;
            if (at !== 1 || bc !== 1 || e !== 1'b1 || ld !== 32'h0 || se !== 0) begin
                errors++;
                $display("FAIL err_case%0d got ack_at=%0d busy=%0d err=%b load=%h stray=%0d want 1 1 1 00000000 0",
                         i, at, bc, e, ld, se);
            end
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (ld !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL err_mem_intact got %h err=%b want cafef00d 0", ld, e);
        end
    endtask

    task automatic test_busy_ignore();
        int at, cnt, bc, se; logic [31:0] ld; logic e;
        int ack_at;
        @(posedge clk); #1;
        addr2 = 32'h20; store2 = 32'h11111111; wen2 = 1'b1;
        ack_at = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin addr2 = 32'h24; store2 = 32'h22222222; end
            if (ack2 && ack_at < 0) begin ack_at = i; wen2 = 1'b0; end
        end
        wen2 = 1'b0;
        checks++;
        if (ack_at !== 3) begin
            errors++;
            $display("FAIL ign_ack got ack_at=%0d want 3", ack_at);
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (ld !== 32'h11111111) begin
            errors++;
            $display("FAIL ign_target got %h want 11111111", ld);
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (ld !== 32'h0 || cnt !== 1) begin
            errors++;
            $display("FAIL ign_other got %h acks=%0d want 00000000 1", ld, cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mask;
        int bad_data;
        mask = 16'h0; bad_data = 0;
        @(posedge clk); #1;
        addr2 = 32'h10; ren2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            mask[i] = ack2;
            if (ack2 && load2 !== 32'hCAFEF00D) bad_data++;
        end
        ren2 = 1'b0;
        // Sample i (0-based) follows edge i+1; acks after edges 3, 7, 11, 15.
        checks++;
        if (mask !== 16'h4444) begin
            errors++;
            $display("FAIL b2b_pattern got %h want 4444", mask);
        end
        checks++;
        if (bad_data !== 0) begin
            errors++;
            $display("FAIL b2b_data got %0d bad reads want 0", bad_data);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_latency0();
        int at, cnt, bc, se; logic [31:0] ld; logic e;
        run_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 1 || bc !== 1 || cnt !== 1 || ld !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL l0_read got ack_at=%0d busy=%0d acks=%0d load=%h err=%b want 1 1 1 00000000 0",
                     at, bc, cnt, ld, e);
        end
        run_req(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 1 || bc !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL l0_write got ack_at=%0d busy=%0d err=%b want 1 1 0", at, bc, e);
        end
        run_req(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (ld !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL l0_readback got %h want a5a5a5a5", ld);
        end
        run_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 1 || e !== 1'b1 || ld !== 32'h0) begin
            errors++;
            $display("FAIL l0_oob got ack_at=%0d err=%b load=%h want 1 1 00000000", at, e, ld);
        end
    endtask

    task automatic test_reset_mid();
        int at, cnt, bc, se; logic [31:0] ld; logic e;
        int late_ack;
        // Make ramload non-zero so the reset clear is visible.
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, at, cnt, bc, se, ld, e);
        @(posedge clk); #1;
        addr2 = 32'h8; store2 = 32'h55AA55AA; wen2 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy2 !== 1'b1 || ack2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got busy=%b ack=%b want 1 0", busy2, ack2);
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if ({busy2, ack2, err2, load2} !== 35'h0) begin
            errors++;
            $display("FAIL mid_async got busy=%b ack=%b err=%b load=%h want all 0",
                     busy2, ack2, err2, load2);
        end
        wen2 = 1'b0;
        @(posedge clk); #1 nRST = 1'b1;
        late_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack2 || busy2) late_ack++;
        end
        checks++;
        if (late_ack !== 0) begin
            errors++;
            $display("FAIL mid_no_ack got %0d active cycles want 0", late_ack);
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (at !== 3 || ld !== 32'h0) begin
            errors++;
            $display("FAIL mid_word8 got ack_at=%0d load=%h want 3 00000000", at, ld);
        end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, at, cnt, bc, se, ld, e);
        checks++;
        if (ld !== 32'h0) begin
            errors++;
            $display("FAIL mid_mem_clear got %h want 00000000", ld);
        end
    endtask

    initial begin
        test_reset();
        test_latency0();
        test_write_read();
        test_errors();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
